// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default operand width.
// Imported by serial_sub_ctrl and fs_bit.
package serial_sub_ctrl_pkg;

  localparam int SUB_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_bit.sv
// One-bit full subtractor (d = a - b - bin), built from two half-subtractor stages plus an OR.
// Purely combinational; no state, no flow control.
module fs_bit
  import serial_sub_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d, hs1_b, hs2_b;

  // a - b
  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  // (a - b) - bin
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b, LSB first, one bit per clk; optional signed-overflow flag under SUB_OVF_EN.
// Latency: done pulses W+1 cycles after the start-accepting edge; start is ignored unless IDLE (no queuing).
// Results (diff, bout, ovf) are registered and hold until the next accepted start.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W) + 1;

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh, b_sh, diff_q;
  logic           bor_q, bout_q;
  logic [CW-1:0]  cnt_q;
  logic           cell_d, cell_bout, last_bit;

`ifdef SUB_OVF_EN
  logic           a_msb_q, b_msb_q, ovf_q;
`endif

  assign last_bit = (cnt_q == CW'(W - 1));

  fs_bit u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Operands shift right past the cell; each result bit enters diff at the MSB so
  // that after W shifts bit 0 of the result sits at diff[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SUB_OVF_EN
            a_msb_q <= a[W-1];
            b_msb_q <= b[W-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[W-1:1]};
          b_sh   <= {1'b0, b_sh[W-1:1]};
          diff_q <= {cell_d, diff_q[W-1:1]};
          bor_q  <= cell_bout;
          cnt_q  <= cnt_q + 1'b1;
          if (last_bit) begin
            bout_q <= cell_bout;
`ifdef SUB_OVF_EN
            // cell_d here is the result MSB
            ovf_q  <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (W=8): vector table, scoreboard on done, corner-case sequences.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb);
    exp_t e;
    e.diff = va - vb;
    e.bout = (va < vb);
    e.ovf  = (va[W-1] ^ vb[W-1]) & (va[W-1] ^ e.diff[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse consumes one expectation pushed at start time.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("busy_with_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got a done pulse, expected none at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_diff", {24'd0, diff}, {24'd0, mon_e.diff});
        check("sb_bout", {31'd0, bout}, {31'd0, mon_e.bout});
`ifdef SUB_OVF_EN
        check("sb_ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
      end
    end
  end

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input exp_t e, input string name);
    int lat, nb;
    sb.push_back(e);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nb = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) nb++;
    end
    check({name, "_lat"}, lat, W + 1);
    check({name, "_busy_cycles"}, nb, W);
    // outputs must hold while inputs wander with start low
    repeat (3) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
    end
    check({name, "_hold_diff"}, {24'd0, diff}, {24'd0, e.diff});
    check({name, "_hold_bout"}, {31'd0, bout}, {31'd0, e.bout});
  endtask

  vec_t vecs[9];
  exp_t e;
  int   lat, d0, t[3], n, cyc;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      e.diff = vecs[i].diff; e.bout = vecs[i].bout; e.ovf = vecs[i].ovf;
      do_op(vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      do_op(ra, rb, model(ra, rb), $sformatf("rnd%0d", i));
    end

    // start with new operands during RUN must be ignored
    e.diff = 8'h02; e.bout = 1'b0; e.ovf = 1'b0;
    sb.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin a = 8'hAA; b = 8'h11; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    check("ign_lat", lat, W + 1);
    repeat (15) @(negedge clk);
    check("ign_done_count", done_cnt - d0, 1);

    // reset in the middle of RUN: no done, outputs cleared
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_diff", {24'd0, diff}, 32'd0);
    check("mid_rst_bout", {31'd0, bout}, 32'd0);
    repeat (15) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    e.diff = 8'hFE; e.bout = 1'b1; e.ovf = 1'b0;
    do_op(8'h03, 8'h05, e, "after_rst");

    // start held high: back-to-back operations spaced W+2 cycles
    e = model(8'h10, 8'h20);
    repeat (3) sb.push_back(e);
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        t[n] = cyc;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_count", n, 3);
    check("held_first_lat", t[0], W + 1);
    check("held_gap1", t[1] - t[0], W + 2);
    check("held_gap2", t[2] - t[1], W + 2);
    repeat (15) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
